// File: rtl/ula_despacho.sv
// ula_despacho
// Issue side of the ULA interface. Takes one register-form instruction at a
// time over a valid/ready handshake. It reads both operands from the
// internal register bank and presents them to the combinational ULA. It
// captures the 32-bit result and returns it over a valid/ready result
// handshake, then writes the low LARGURA bits back into the bank.
//
// Configuration macro: ULA_DESPACHO_DIV0_EN
//   defined   -> opcode 00111 with operand2 == 0 is trapped
//                (res_dado = FFFF_FFFF, res_erro = 1, no writeback)
//   undefined -> divide-by-zero goes through the ULA like any other op
//
// Ports
//   clock, resetn                       clock (rising edge), async active-low reset
//   instr_valid/instr_ready             instruction handshake
//   instr_opcode/rd/rs1/rs2             instruction fields
//   ula_operando1/2, ula_opcode         drive the ULA (0 while idle)
//   ula_resultado                       ULA result, combinational
//   res_valid/res_ready                 result handshake
//   res_dado/res_rd/res_erro            captured result, destination, error flag
//   dbg_sel/dbg_dado                    combinational debug read of the bank
module ula_despacho #(
  parameter  int NREG    = 8,
  parameter  int LARGURA = 16,
  localparam int IW      = $clog2(NREG)
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [4:0]         instr_opcode,
  input  logic [IW-1:0]      instr_rd,
  input  logic [IW-1:0]      instr_rs1,
  input  logic [IW-1:0]      instr_rs2,
  output logic [LARGURA-1:0] ula_operando1,
  output logic [LARGURA-1:0] ula_operando2,
  output logic [4:0]         ula_opcode,
  input  logic [31:0]        ula_resultado,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [31:0]        res_dado,
  output logic [IW-1:0]      res_rd,
  output logic               res_erro,
  input  logic [IW-1:0]      dbg_sel,
  output logic [LARGURA-1:0] dbg_dado
);

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    EXECUTA = 2'd1,
    ENTREGA = 2'd2
  } estado_t;

  estado_t r_estado;
  estado_t w_prox;

  logic [LARGURA-1:0] r_bank [NREG];
  logic [LARGURA-1:0] r_op1;
  logic [LARGURA-1:0] r_op2;
  logic [4:0]         r_opcode;
  logic [IW-1:0]      r_rd;
  logic [31:0]        r_res_dado;
  logic [IW-1:0]      r_res_rd;
  logic               r_res_erro;

  logic               w_aceita;
  logic               w_captura;
  logic               w_conclui;
  logic               w_opcode_ok;
  logic               w_trap;
  logic [LARGURA-1:0] w_le1;
  logic [LARGURA-1:0] w_le2;

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_estado <= OCIOSO;
    end else begin
      r_estado <= w_prox;
    end
  end

  // Next-state and handshake decode. An instruction offered outside OCIOSO
  // is simply not acknowledged; nothing is queued.
  always_comb begin
    w_prox      = r_estado;
    instr_ready = 1'b0;
    res_valid   = 1'b0;
    w_aceita    = 1'b0;
    w_captura   = 1'b0;
    w_conclui   = 1'b0;
    case (r_estado)
      OCIOSO: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          w_aceita = 1'b1;
          w_prox   = EXECUTA;
        end
      end
      EXECUTA: begin
        w_captura = 1'b1;
        w_prox    = ENTREGA;
      end
      ENTREGA: begin
        res_valid = 1'b1;
        if (res_ready) begin
          w_conclui = 1'b1;
          w_prox    = OCIOSO;
        end
      end
      default: w_prox = OCIOSO;
    endcase
  end

  // r0 is hard-wired to zero on every read port.
  assign w_le1    = (instr_rs1 == '0) ? '0 : r_bank[instr_rs1];
  assign w_le2    = (instr_rs2 == '0) ? '0 : r_bank[instr_rs2];
  assign dbg_dado = (dbg_sel == '0) ? '0 : r_bank[dbg_sel];

  assign w_opcode_ok = (r_opcode == 5'b00010) ||
                       ((r_opcode >= 5'b00100) && (r_opcode <= 5'b01101));

`ifdef ULA_DESPACHO_DIV0_EN
  assign w_trap = (r_opcode == 5'b00111) && (r_op2 == '0);
`else
  assign w_trap = 1'b0;
`endif

  // The ULA only sees live operands while an instruction is in flight.
  assign ula_operando1 = (r_estado == OCIOSO) ? '0 : r_op1;
  assign ula_operando2 = (r_estado == OCIOSO) ? '0 : r_op2;
  assign ula_opcode    = (r_estado == OCIOSO) ? '0 : r_opcode;

  assign res_dado = r_res_dado;
  assign res_rd   = r_res_rd;
  assign res_erro = r_res_erro;

  // Operand capture on accept. The bank is sampled here, so rs == rd reads
  // the old value, and an earlier writeback is already visible.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_op1    <= '0;
      r_op2    <= '0;
      r_opcode <= '0;
      r_rd     <= '0;
    end else if (w_aceita) begin
      r_op1    <= w_le1;
      r_op2    <= w_le2;
      r_opcode <= instr_opcode;
      r_rd     <= instr_rd;
    end
  end

  // Result capture at the end of EXECUTA. Bad opcodes and trapped divides
  // ignore the ULA output entirely.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_res_dado <= '0;
      r_res_rd   <= '0;
      r_res_erro <= 1'b0;
    end else if (w_captura) begin
      r_res_rd <= r_rd;
      if (!w_opcode_ok) begin
        r_res_dado <= '0;
        r_res_erro <= 1'b1;
      end else if (w_trap) begin
        r_res_dado <= 32'hFFFF_FFFF;
        r_res_erro <= 1'b1;
      end else begin
        r_res_dado <= ula_resultado;
        r_res_erro <= 1'b0;
      end
    end
  end

  // Writeback happens only on the result handshake. Only the low LARGURA
  // bits are kept. Writes to r0 and errored results are dropped.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREG; i++) begin
        r_bank[i] <= '0;
      end
    end else if (w_conclui && (r_res_rd != '0) && !r_res_erro) begin
      r_bank[r_res_rd] <= r_res_dado[LARGURA-1:0];
    end
  end

endmodule

// File: tb/tb_ula_despacho.sv
// tb_ula_despacho
// Directed bench for ula_despacho. The bench plays the ULA and keeps its own
// register-bank model. It queues the expected result of every accepted
// instruction and compares it when the result handshake comes out.
module tb_ula_despacho;

  logic        clock;
  logic        resetn;
  logic        instr_valid;
  logic        instr_ready;
  logic [4:0]  instr_opcode;
  logic [2:0]  instr_rd;
  logic [2:0]  instr_rs1;
  logic [2:0]  instr_rs2;
  logic [15:0] ula_operando1;
  logic [15:0] ula_operando2;
  logic [4:0]  ula_opcode;
  logic [31:0] ula_resultado;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_dado;
  logic [2:0]  res_rd;
  logic        res_erro;
  logic [2:0]  dbg_sel;
  logic [15:0] dbg_dado;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  rd;
    logic [31:0] dado;
    logic        erro;
  } resT;

  resT         sbq[$];
  logic [15:0] mBank [8];

  logic        ulaForca;
  logic [31:0] ulaValor;

  ula_despacho dut (
    .clock        (clock),
    .resetn       (resetn),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_opcode (instr_opcode),
    .instr_rd     (instr_rd),
    .instr_rs1    (instr_rs1),
    .instr_rs2    (instr_rs2),
    .ula_operando1(ula_operando1),
    .ula_operando2(ula_operando2),
    .ula_opcode   (ula_opcode),
    .ula_resultado(ula_resultado),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_dado     (res_dado),
    .res_rd       (res_rd),
    .res_erro     (res_erro),
    .dbg_sel      (dbg_sel),
    .dbg_dado     (dbg_dado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Stand-in ULA: add, sub, mul and div are real. Div by zero gives
  // 0000_FFFF. Everything else is XOR. ulaForca lets a step inject an
  // arbitrary result, for example to load a register.
  function automatic logic [31:0] ulaFn(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] ea;
    logic [31:0] eb;
    ea = {16'h0000, a};
    eb = {16'h0000, b};
    case (op)
      5'b00100: return ea + eb;
      5'b00101: return ea - eb;
      5'b00110: return ea * eb;
      5'b00111: return (b == 16'h0000) ? 32'h0000_FFFF : ea / eb;
      default:  return ea ^ eb;
    endcase
  endfunction

  always_comb begin
    if (ulaForca) ula_resultado = ulaValor;
    else          ula_resultado = ulaFn(ula_opcode, ula_operando1, ula_operando2);
  end

  function automatic logic [15:0] leModelo(input logic [2:0] idx);
    return (idx == 3'd0) ? 16'h0000 : mBank[idx];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for the block to be ready, then offer one instruction and push its
  // expected result. On return we are #1 into the EXECUTA cycle.
  task automatic applyStimulus(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                               input logic [2:0] rs2, input logic frc, input logic [31:0] fv);
    int   cnt;
    resT  e;
    logic [15:0] a;
    logic [15:0] b;
    logic ok;
    cnt = 0;
    while (!instr_ready && cnt < 20) begin
      @(posedge clock); #1;
      cnt++;
    end
    check("instr_ready_before_issue", instr_ready, 1'b1);
    a  = leModelo(rs1);
    b  = leModelo(rs2);
    ok = (op == 5'b00010) || ((op >= 5'b00100) && (op <= 5'b01101));
    e.rd = rd;
    if (!ok) begin
      e.dado = 32'h0;
      e.erro = 1'b1;
    end else begin
`ifdef ULA_DESPACHO_DIV0_EN
      if (op == 5'b00111 && b == 16'h0000) begin
        e.dado = 32'hFFFF_FFFF;
        e.erro = 1'b1;
      end else begin
        e.dado = frc ? fv : ulaFn(op, a, b);
        e.erro = 1'b0;
      end
`else
      e.dado = frc ? fv : ulaFn(op, a, b);
      e.erro = 1'b0;
`endif
    end
    sbq.push_back(e);
    ulaForca     = frc;
    ulaValor     = fv;
    instr_opcode = op;
    instr_rd     = rd;
    instr_rs1    = rs1;
    instr_rs2    = rs2;
    instr_valid  = 1'b1;
    @(posedge clock); #1;
    instr_valid = 1'b0;
    check("exec_ula_opcode", ula_opcode, op);
    check("exec_operando1", ula_operando1, a);
    check("exec_operando2", ula_operando2, b);
    check("exec_res_valid_low", res_valid, 1'b0);
  endtask

  // Wait (bounded) for res_valid and compare against the head of the queue.
  task automatic checkOutput();
    int cnt;
    cnt = 0;
    while (!res_valid && cnt < 10) begin
      @(posedge clock); #1;
      cnt++;
    end
    check("latency_cycles", cnt, 1);
    if (sbq.size() == 0) begin
      check("scoreboard_nonempty", 0, 1);
    end else begin
      check("res_valid", res_valid, 1'b1);
      check("res_dado", res_dado, sbq[0].dado);
      check("res_rd", res_rd, sbq[0].rd);
      check("res_erro", res_erro, sbq[0].erro);
      check("instr_ready_busy", instr_ready, 1'b0);
    end
  endtask

  // Complete the result handshake and update the bank model.
  task automatic finishResult();
    resT e;
    res_ready = 1'b1;
    @(posedge clock); #1;
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      if (e.rd != 3'd0 && !e.erro) mBank[e.rd] = e.dado[15:0];
    end
    check("idle_res_valid", res_valid, 1'b0);
    check("idle_instr_ready", instr_ready, 1'b1);
    check("idle_ula_opcode", ula_opcode, 5'b0);
    check("idle_operando1", ula_operando1, 16'h0);
  endtask

  task automatic runInstr(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                          input logic [2:0] rs2, input logic frc, input logic [31:0] fv);
    applyStimulus(op, rd, rs1, rs2, frc, fv);
    checkOutput();
    finishResult();
  endtask

  task automatic checkBank(input logic [2:0] idx);
    dbg_sel = idx;
    #1;
    check($sformatf("dbg_r%0d", idx), dbg_dado, leModelo(idx));
  endtask

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [31:0] stalled;
    resetn       = 1'b0;
    instr_valid  = 1'b0;
    instr_opcode = '0;
    instr_rd     = '0;
    instr_rs1    = '0;
    instr_rs2    = '0;
    res_ready    = 1'b1;
    dbg_sel      = '0;
    ulaForca     = 1'b0;
    ulaValor     = '0;
    for (int i = 0; i < 8; i++) mBank[i] = 16'h0;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst_instr_ready", instr_ready, 1'b1);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_dado", res_dado, 32'h0);
    check("rst_res_rd", res_rd, 3'd0);
    check("rst_res_erro", res_erro, 1'b0);
    check("rst_ula_opcode", ula_opcode, 5'b0);
    check("rst_operando2", ula_operando2, 16'h0);
    resetn = 1'b1;
    @(posedge clock); #1;

    // r1=5, r2=3, then r3 = r1 + r2
    runInstr(5'b00010, 3'd1, 3'd0, 3'd0, 1'b1, 32'd5);
    runInstr(5'b00010, 3'd2, 3'd0, 3'd0, 1'b1, 32'd3);
    runInstr(5'b00100, 3'd3, 3'd1, 3'd2, 1'b0, 32'd0);
    checkBank(3'd3);
    check("add_result_r3", dbg_dado, 16'd8);

    // Multiply: the upper half is reported but only the low half is written back
    runInstr(5'b00010, 3'd1, 3'd0, 3'd0, 1'b1, 32'h0100);
    runInstr(5'b00010, 3'd2, 3'd0, 3'd0, 1'b1, 32'h0200);
    applyStimulus(5'b00110, 3'd4, 3'd1, 3'd2, 1'b0, 32'd0);
    checkOutput();
    check("mul_res_dado", res_dado, 32'h0002_0000);
    finishResult();
    checkBank(3'd4);

    // Consumer stalls for 5 cycles while another instruction is offered
    res_ready = 1'b0;
    applyStimulus(5'b00101, 3'd5, 3'd3, 3'd2, 1'b0, 32'd0);
    checkOutput();
    stalled = res_dado;
    for (int i = 0; i < 5; i++) begin
      instr_opcode = 5'b00100;
      instr_rd     = 3'd6;
      instr_rs1    = 3'd3;
      instr_rs2    = 3'd3;
      instr_valid  = 1'b1;
      @(posedge clock); #1;
      check("stall_res_valid", res_valid, 1'b1);
      check("stall_res_dado", res_dado, stalled);
      check("stall_instr_ready", instr_ready, 1'b0);
    end
    instr_valid = 1'b0;
    finishResult();
    repeat (2) begin
      @(posedge clock); #1;
      check("stall_not_queued", res_valid, 1'b0);
    end
    checkBank(3'd5);
    checkBank(3'd6);

    // Bad opcodes on both sides of the valid range, plus the valid top edge
    runInstr(5'b11111, 3'd2, 3'd3, 3'd3, 1'b1, 32'h1234_5678);
    checkBank(3'd2);
    check("bad_op_r2_kept", dbg_dado, 16'h0200);
    runInstr(5'b00011, 3'd5, 3'd1, 3'd2, 1'b1, 32'h0000_0055);
    runInstr(5'b01110, 3'd5, 3'd1, 3'd2, 1'b1, 32'h0000_0066);
    runInstr(5'b01101, 3'd5, 3'd1, 3'd2, 1'b1, 32'h0000_00AA);
    checkBank(3'd5);

    // Divide by zero (trapped or passed through depending on the build), then a normal divide
    runInstr(5'b00111, 3'd6, 3'd3, 3'd0, 1'b0, 32'd0);
    checkBank(3'd6);
    runInstr(5'b00111, 3'd7, 3'd2, 3'd5, 1'b0, 32'd0);
    checkBank(3'd7);

    // Writes to r0 are dropped; rs1 = rs2 = rd reads the old value
    runInstr(5'b00100, 3'd0, 3'd3, 3'd3, 1'b0, 32'd0);
    checkBank(3'd0);
    runInstr(5'b00100, 3'd3, 3'd3, 3'd3, 1'b0, 32'd0);
    checkBank(3'd3);
    check("self_add_r3", dbg_dado, 16'd16);

    // Reset in the middle of EXECUTA discards the instruction and clears the bank
    applyStimulus(5'b00100, 3'd7, 3'd3, 3'd3, 1'b0, 32'd0);
    resetn = 1'b0;
    @(posedge clock); #1;
    check("midrst_res_valid", res_valid, 1'b0);
    check("midrst_instr_ready", instr_ready, 1'b1);
    check("midrst_res_dado", res_dado, 32'h0);
    check("midrst_ula_operando1", ula_operando1, 16'h0);
    sbq.delete();
    for (int i = 0; i < 8; i++) mBank[i] = 16'h0;
    for (int i = 0; i < 8; i++) checkBank(3'(i));
    resetn = 1'b1;
    @(posedge clock); #1;
    runInstr(5'b00010, 3'd1, 3'd0, 3'd0, 1'b1, 32'h002A);
    checkBank(3'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
